seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered digit data.
// A shadow buffer collects loads at any time; it is promoted to the active
// buffer only at the end of a scan frame, so a frame never shows mixed data.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, sh_en_q, sh_en_d;
    logic                    pend_q, pend_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick, wrap;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    zacc;
    logic [3:0]              cur_nib;
    logic                    blank;

    // Active-low a..g pattern for one hex nibble; seg[6] is segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Prescaler, digit index and buffer next-state.
    always_comb begin
        tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        wrap       = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        pend_d     = pend_q;
        if (wrap) begin
            if (pend_q) begin
                act_data_d = sh_data_q;
                act_dp_d   = sh_dp_q;
                act_en_d   = sh_en_q;
            end
            pend_d = 1'b0;
        end
        // A load on the wrap cycle lands in shadow and waits for the next frame.
        if (load) begin
            sh_data_d = data_in;
            sh_dp_d   = dp_in;
            sh_en_d   = digit_en;
            pend_d    = 1'b1;
        end
    end

    // Blanking decision and registered segment/anode drive for the current slot.
    always_comb begin
        zero_above = '0;
        zacc       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zacc          = zacc && (act_data_q[4*i +: 4] == 4'h0);
            zero_above[i] = zacc;
        end
        cur_nib = act_data_q[{idx_q, 2'b00} +: 4];
        blank   = !act_en_q[idx_q] ||
                  (lz_blank && (idx_q != '0) && zero_above[idx_q]);
        seg_d   = blank ? 8'hFF : {~act_dp_q[idx_q], hex_to_seg(cur_nib)};
        an_d    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !(!blank && (idx_q == IDX_W'(i)));
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '0;
            pend_q     <= 1'b0;
            seg_q      <= 8'hFF;
            an_q       <= '1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = wrap && !rst;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4 cycles per slot).
module tb_seg7_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   data_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          lz_blank;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic          frame_done;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] an;
        logic [3:0][7:0] seg;
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     gap   = 0;
    logic   rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge <= rst;

    function automatic frame_t mk(input logic [15:0] an_all, input logic [31:0] seg_all);
        frame_t f;
        f.an  = an_all;
        f.seg = seg_all;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the edge that starts the frame_done cycle.
    task automatic wait_wrap();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 40);
        if (!frame_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wrap_timeout: got no frame_done, expected one within 40 cycles");
        end
    endtask

    task automatic next_frame(input frame_t f);
        exp_q.push_back(f);
        wait_wrap();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        load     = 1'b1;
        data_in  = d;
        dp_in    = dp;
        digit_en = en;
        tick(1);
        load     = 1'b0;
    endtask

    // Scoreboard monitor: after each frame_done, check every slot of the new frame.
    initial begin : sb_mon
        frame_t f;
        forever begin
            @(negedge clk);
            if (frame_done && exp_q.size() > 0) begin
                f = exp_q.pop_front();
                repeat (2) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("slot%0d_an", k), {28'd0, an}, {28'd0, f.an[k]});
                    check($sformatf("slot%0d_seg", k), {24'd0, seg}, {24'd0, f.seg[k]});
                    if (k < 3) repeat (4) @(negedge clk);
                end
            end
        end
    end

    // Reset outputs and frame period (16 cycles from reset release or last pulse).
    initial begin : per_mon
        forever begin
            @(negedge clk);
            gap++;
            if (rst_at_edge) begin
                check("rst_seg", {24'd0, seg}, 32'hFF);
                check("rst_an", {28'd0, an}, 32'hF);
                check("rst_frame_done", {31'd0, frame_done}, 32'd0);
            end
            if (rst) begin
                gap = 0;
            end else if (frame_done) begin
                check("frame_period", gap, 32'd16);
                gap = 0;
            end
        end
    end

    initial begin : stim
        frame_t blank_f, l_f, lz5_f, lz0_f, b_f, c_f;
        blank_f = mk(16'hFFFF, 32'hFFFF_FFFF);
        l_f     = mk(16'h7BDE, 32'hCF92_8838);
        lz5_f   = mk(16'hFFFE, 32'hFFFF_FFA4);
        lz0_f   = mk(16'hFFFE, 32'hFFFF_FF81);
        b_f     = mk(16'h7FDE, 32'h00FF_01B0);
        c_f     = mk(16'hFFDE, 32'hFFFF_B18F);

        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; digit_en = '0; lz_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: blank frames.
        next_frame(blank_f);
        next_frame(blank_f);
        // Mid-frame load shows only from the next frame.
        tick(5);
        do_load(16'h12AF, 4'b0001, 4'b1111);
        next_frame(l_f);
        // Leading-zero suppression.
        tick(3);
        do_load(16'h0005, 4'b0000, 4'b1111);
        next_frame(lz5_f);
        lz_blank = 1'b1;
        tick(3);
        do_load(16'h0000, 4'b0000, 4'b1111);
        next_frame(lz0_f);
        // Double buffer: A then B in one frame; only B appears.
        tick(3);
        do_load(16'h1234, 4'b0000, 4'b1111);
        tick(4);
        do_load(16'h8D0E, 4'b1010, 4'b1011);
        next_frame(b_f);
        // Load coincident with the wrap shows one frame later.
        do_load(16'h00C7, 4'b0000, 4'b1111);
        next_frame(c_f);
        // Mid-frame reset at digit 2 with a load pending.
        wait_wrap();
        tick(5);
        do_load(16'hFFFF, 4'b1111, 4'b1111);
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        next_frame(blank_f);
        next_frame(blank_f);
        tick(20);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
